// File: rtl/stk_arb_pkg.sv
// Shared types and encodings for the stack arbiter block.
package stk_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin by default, fixed priority (port 0 wins)
// when STK_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import stk_arb_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic               idx
);

`ifdef STK_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{CLK, RESET, adv};

  always_comb begin
    idx = REQ0;
    gnt = '0;
    if (req[REQ0]) begin
      idx      = REQ0;
      gnt[0]   = 1'b1;
    end else if (req[REQ1]) begin
      idx      = REQ1;
      gnt[1]   = 1'b1;
    end
  end
`else
  // ptr names the requester that wins the next simultaneous request
  logic ptr;

  always_comb begin
    idx = REQ0;
    gnt = '0;
    if (&req)
      idx = ptr;
    else
      idx = req[REQ1];
    if (|req) begin
      if (idx == REQ1) gnt[1] = 1'b1;
      else             gnt[0] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      ptr <= REQ0;
    else if (adv)
      ptr <= ~idx;
  end
`endif

endmodule

// File: rtl/stack_arbiter.sv
// Two-port arbiter/sequencer in front of the shared stack: one push/pop per
// 3-cycle transaction, full/empty checked before any strobe.
// Optional: STK_ARB_FIXED_PRIO_EN makes requester 0 win simultaneous requests.
module stack_arbiter
  import stk_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int WL = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          op0,
  input  logic [WL-1:0] wd0,
  output logic          ack0,
  output logic          nak0,
  output logic [WL-1:0] rd0,
  input  logic          req1,
  input  logic          op1,
  input  logic [WL-1:0] wd1,
  output logic          ack1,
  output logic          nak1,
  output logic [WL-1:0] rd1,
  output logic          st_push,
  output logic          st_pop,
  output logic [WL-1:0] st_di,
  input  logic [WL-1:0] st_data,
  input  logic [N-1:0]  st_sp,
  input  logic          st_full,
  input  logic          st_empty,
  input  logic          st_error,
  output logic          busy,
  output logic          last_gnt,
  output logic          stk_err
);

  state_t               state;
  logic                 gnt_q;
  logic                 op_q;
  logic [WL-1:0]        wd_q;
  logic [NUM_REQ-1:0]   req_v;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic                 win;
  logic                 adv;
  logic                 illegal;
  logic                 fire;
  logic                 op_sel;
  logic [WL-1:0]        wd_sel;
  logic                 unused_sp;

  assign unused_sp = ^st_sp;

  assign req_v = {req1, req0};
  assign adv   = (state == IDLE) && (|req_v);

  rr_arb2 u_arb (
    .CLK   (CLK),
    .RESET (RESET),
    .req   (req_v),
    .adv   (adv),
    .gnt   (gnt_oh),
    .idx   (win)
  );

  assign op_sel = gnt_oh[1] ? op1 : op0;
  assign wd_sel = gnt_oh[1] ? wd1 : wd0;

  // Stack status is stable between IDLE and GRANT because only this block
  // moves the pointer, so checking in GRANT sees the true pre-op state.
  assign illegal = (op_q == OP_PUSH) ? st_full : st_empty;
  assign fire    = (state == GRANT) && !illegal && !RESET;

  assign st_push = fire && (op_q == OP_PUSH);
  assign st_pop  = fire && (op_q == OP_POP);
  assign st_di   = wd_q;
  assign busy    = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      gnt_q    <= REQ0;
      op_q     <= OP_POP;
      wd_q     <= '0;
      last_gnt <= REQ0;
      ack0     <= 1'b0;
      nak0     <= 1'b0;
      ack1     <= 1'b0;
      nak1     <= 1'b0;
      rd0      <= '0;
      rd1      <= '0;
      stk_err  <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      nak0 <= 1'b0;
      ack1 <= 1'b0;
      nak1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_v) begin
            gnt_q    <= win;
            op_q     <= op_sel;
            wd_q     <= wd_sel;
            last_gnt <= win;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Response is registered here so it appears in RESP; pop data is
          // the top word before the pop lands.
          if (gnt_q == REQ1) begin
            ack1 <= !illegal;
            nak1 <= illegal;
            if (!illegal && op_q == OP_POP) rd1 <= st_data;
          end else begin
            ack0 <= !illegal;
            nak0 <= illegal;
            if (!illegal && op_q == OP_POP) rd0 <= st_data;
          end
          state <= RESP;
        end
        RESP: begin
          if (st_error) stk_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared `stack` block (CALL/RET unit on port 0, interrupt/context unit on port 1).
- Accepts one push or pop transaction at a time and issues exactly one single-cycle `push`/`pop` strobe to the stack.
- Returns pop data to the requester and completes every transaction with either `ack` or `nak`.
- Checks full/empty before issuing, so an illegal access never reaches the stack.

Parameters:
- N, 4, stack depth; width of the stack pointer observed on `st_sp`.
- WL, 3, data word length in bits.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request level.
- op0  in  1  requester 0 operation: 1 = push, 0 = pop.
- wd0  in  WL  requester 0 push data.
- ack0  out  1  requester 0 transaction done OK; one-cycle pulse.
- nak0  out  1  requester 0 transaction rejected; one-cycle pulse.
- rd0  out  WL  requester 0 pop data; valid while `ack0` is high.
- req1, op1, wd1, ack1, nak1, rd1: same as port 0, for requester 1.
- st_push  out  1  push strobe to the stack.
- st_pop  out  1  pop strobe to the stack.
- st_di  out  WL  data to the stack.
- st_data  in  WL  current top-of-stack word from the stack.
- st_sp  in  N  stack pointer (status only).
- st_full  in  1  stack full.
- st_empty  in  1  stack empty.
- st_error  in  1  stack error flag.
- busy  out  1  arbiter not in IDLE.
- last_gnt  out  1  index of the most recently granted requester.
- stk_err  out  1  sticky: `st_error` was seen high in a RESP cycle.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, round-robin pointer selects requester 0 first.
- Reset mid-transaction: FSM returns to IDLE; `st_push`/`st_pop` are 0 in that cycle; no `ack`/`nak` is emitted for the aborted transaction.
- FSM states: IDLE -> GRANT -> RESP -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE:
  - If any `req` is high, select a winner; latch its index, op and write data; go to GRANT.
  - If both request, the round-robin pointer decides; otherwise the single requester wins.
  - After each grant the pointer moves to the non-granted requester.
  - `last_gnt` updates on entry to GRANT.
- GRANT:
  - Push with `st_full`=1, or pop with `st_empty`=1: no strobe, transaction marked rejected.
  - Otherwise drive exactly one cycle of `st_push` (with `st_di` = latched data) or `st_pop`.
  - On a pop, capture `st_data` in this cycle, i.e. the value before the pop takes effect.
  - Next state is RESP.
- RESP:
  - Pulse the granted requester's `ack` or `nak` for one cycle; `rd` is valid with `ack`.
  - `rd` holds its value until the next ack on that port.
  - If `st_error`=1 in this cycle, set `stk_err` (cleared only by RESET).
  - Next state is IDLE.
- Requester rules:
  - Hold `req`, `op` and `wd` stable from assertion until `ack`/`nak` is seen.
  - A `req` still high in the cycle after RESP counts as a new transaction.
- `st_push` and `st_pop` are never high together, and are high only in GRANT.
- Latency: `req` high in IDLE cycle T produces the stack strobe at T+1 and `ack`/`nak` at T+2.
- Back-to-back transactions: minimum 3 cycles per transaction.
- The unserved requester keeps waiting; it is granted in the next IDLE.

Optional Feature:
- Macro: STK_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins a simultaneous request; the round-robin pointer is removed; `last_gnt` still reports the grant.
- Undefined: round-robin as specified above.

Decomposition:
- Package `stk_arb_pkg`:
  - state enum (IDLE, GRANT, RESP);
  - op encoding constants OP_PUSH=1, OP_POP=0;
  - requester index constants.
- Sub-module `rr_arb2`:
  - inputs: 2 request bits, an advance strobe;
  - outputs: one-hot grant and winner index;
  - holds the pointer;
  - becomes fixed priority under STK_ARB_FIXED_PRIO_EN.
- `stack_arbiter` contains the FSM, legality check, data capture and sticky error logic.

Test Plan:
- Reset, then req0 push 1, 2, 4 in sequence -> three `st_push` pulses with `st_di`=1, 2, 4; `ack0` at T+2 of each; `nak0` never high.
- Fill the stack to N=4 via req1, then req1 push 7 -> no `st_push`; `nak1` pulse; `st_sp` unchanged.
- From a stack holding 1, 2, 4, 5, req0 pop twice -> `rd0`=5 then 4, each with `ack0`; one `st_pop` per transaction.
- req0 and req1 raised in the same cycle and held; repeat with both still requesting -> grants alternate 0, 1, 0, 1 and `last_gnt` follows; under STK_ARB_FIXED_PRIO_EN all four go to port 0 while req0 stays high.
- Empty stack, req1 pop -> `nak1`, no `st_pop`; then push 2 -> `ack1`; then pop -> `rd1`=2.
- RESET asserted during GRANT -> no `ack`/`nak` appears, `busy`=0 next cycle, `stk_err`=0; `st_error` forced high during RESP -> `stk_err` stays 1 until RESET.
